// File: rtl/cpu_dbg_pkg.sv
// Shared constants for the CPU debug read path: state encodings and default widths.
package cpu_dbg_pkg;

    localparam int DEFAULT_DATA_W   = 16;
    localparam int DEFAULT_NUM_REGS = 8;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] READ = 3'd1;
    localparam logic [2:0] CAPT = 3'd2;
    localparam logic [2:0] SEND = 3'd3;
    localparam logic [2:0] CSUM = 3'd4;
    localparam logic [2:0] DONE = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE = IDLE,
        S_READ = READ,
        S_CAPT = CAPT,
        S_SEND = SEND,
        S_CSUM = CSUM,
        S_DONE = DONE
    } state_t;

endpackage

// File: rtl/reg_dump_reader.sv
// Reads R0..R(NUM_REGS-1) from the register bank and streams them over valid/ready.
// Define REG_DUMP_CHECKSUM_EN to append a modulo-2**DATA_W sum word at index NUM_REGS.
module reg_dump_reader
    import cpu_dbg_pkg::*;
#(
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = 3
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W:0]   out_index,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t            state;
    logic [ADDR_W-1:0] idx;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] sum;
`endif

    // NOTE: every register here is updated with <= so all branches see the
    // pre-edge values; a later <= in the same pass overrides the done default.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_addr   <= '0;
            out_data  <= '0;
            out_index <= '0;
            out_valid <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            sum       <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        idx     <= '0;
                        rd_addr <= '0;
                        busy    <= 1'b1;
                        state   <= S_READ;
`ifdef REG_DUMP_CHECKSUM_EN
                        sum     <= '0;
`endif
                    end
                end
                // Bank latches rd_addr this cycle; data is visible in CAPT.
                S_READ: state <= S_CAPT;
                S_CAPT: begin
                    out_data  <= rd_data;
                    out_index <= {1'b0, idx};
                    out_valid <= 1'b1;
                    state     <= S_SEND;
`ifdef REG_DUMP_CHECKSUM_EN
                    sum       <= sum + rd_data;
`endif
                end
                S_SEND: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        if (idx == LAST_IDX) begin
`ifdef REG_DUMP_CHECKSUM_EN
                            state <= S_CSUM;
`else
                            done  <= 1'b1;
                            state <= S_DONE;
`endif
                        end else begin
                            idx     <= idx + 1'b1;
                            rd_addr <= idx + 1'b1;
                            state   <= S_READ;
                        end
                    end
                end
`ifdef REG_DUMP_CHECKSUM_EN
                // One idle cycle first keeps valid from staying high across words.
                S_CSUM: begin
                    if (!out_valid) begin
                        out_data  <= sum;
                        out_index <= (ADDR_W+1)'(NUM_REGS);
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                        state     <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: 8-register dump, stall, ignored restart,
// mid-dump reset, optional checksum word and a 2-register instance.
module tb_reg_dump_reader;

    localparam int NR = 8;
    localparam int DW = 16;
    localparam int AW = 3;
`ifdef REG_DUMP_CHECKSUM_EN
    localparam int NW      = NR + 1;
    localparam int NW2     = 3;
    localparam int CS_XTRA = 2;
`else
    localparam int NW      = NR;
    localparam int NW2     = 2;
    localparam int CS_XTRA = 0;
`endif

    logic          CLK = 1'b0;
    logic          reset, start, out_ready;
    logic          busy, done, out_valid;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data, out_data;
    logic [AW:0]   out_index;

    logic          start2, out_ready2;
    logic          busy2, done2, out_valid2;
    logic [0:0]    rd_addr2;
    logic [DW-1:0] rd_data2, out_data2;
    logic [1:0]    out_index2;

    logic [DW-1:0] mem [NR];
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] exp_mem [NR];

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    // Behavioural bank: enable-written registers, registered read port.
    always @(posedge CLK) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data  <= mem[rd_addr];
        rd_data2 <= mem[{2'b00, rd_addr2}];
    end

    reg_dump_reader #(.NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW)) dut (
        .CLK(CLK), .reset(reset), .start(start), .busy(busy), .done(done),
        .rd_addr(rd_addr), .rd_data(rd_data), .out_data(out_data),
        .out_index(out_index), .out_valid(out_valid), .out_ready(out_ready)
    );

    reg_dump_reader #(.NUM_REGS(2), .DATA_W(DW), .ADDR_W(1)) dut2 (
        .CLK(CLK), .reset(reset), .start(start2), .busy(busy2), .done(done2),
        .rd_addr(rd_addr2), .rd_data(rd_data2), .out_data(out_data2),
        .out_index(out_index2), .out_valid(out_valid2), .out_ready(out_ready2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] word_exp(input int k);
        logic [DW-1:0] s = '0;
        if (k < NR) return exp_mem[k];
        for (int i = 0; i < NR; i++) s = s + exp_mem[i];
        return s;
    endfunction

    task automatic load_bank(input int mode);
        for (int i = 0; i < NR; i++) begin
            wr_en   = 1'b1;
            wr_addr = AW'(i);
            if (mode == 0) wr_data = DW'(16'h1111 * (i + 1));
            else           wr_data = (i == 0) ? 16'hFFFF : (i == 1) ? 16'h0002 : 16'h0000;
            exp_mem[i] = wr_data;
            @(negedge CLK);
        end
        wr_en = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
        check({tag, "_addr"},  32'(rd_addr), 32'd0);
        check({tag, "_data"},  32'(out_data), 32'd0);
        check({tag, "_index"}, 32'(out_index), 32'd0);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
    endtask

    // Cycle 0 is the cycle in which start is high; sampling is on negedges.
    task automatic dump(input string tag, input int stall_word, input int stall_len,
                        input int restart_after,
                        output int nwords, output int first_v, output int last_hs,
                        output int done_cyc, output int ndone, output int max_idx);
        int cyc = 1;
        int stall_cnt = 0;
        bit restarted = 0;
        bit finished = 0;
        nwords = 0; first_v = -1; last_hs = -1; done_cyc = -1; ndone = 0; max_idx = 0;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        while (cyc < 300 && !finished) begin
            out_ready = 1'b1;
            start     = 1'b0;
            if (restart_after >= 0 && !restarted && nwords == restart_after + 1) begin
                start     = 1'b1;
                restarted = 1;
            end
            if (out_valid) begin
                if (first_v < 0) first_v = cyc;
                if (int'(out_index) > max_idx) max_idx = int'(out_index);
                if (int'(out_index) == stall_word && stall_cnt < stall_len) begin
                    out_ready = 1'b0;
                    stall_cnt++;
                    check({tag, "_stall_data"},  32'(out_data), 32'(word_exp(stall_word)));
                    check({tag, "_stall_index"}, 32'(out_index), 32'(stall_word));
                end else begin
                    check({tag, "_word_data"},  32'(out_data), 32'(word_exp(nwords)));
                    check({tag, "_word_index"}, 32'(out_index), 32'(nwords));
                    nwords++;
                    last_hs = cyc;
                end
            end
            if (done) begin
                ndone++;
                done_cyc = cyc;
            end
            if (done_cyc >= 0 && !done && !busy) finished = 1;
            else begin
                @(negedge CLK);
                cyc++;
            end
        end
        start = 1'b0;
        if (!finished) check({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        int nw, fv, lh, dc, nd, mx;
        int cyc;
        bit found;
        reset = 1'b1; start = 1'b0; out_ready = 1'b1;
        start2 = 1'b0; out_ready2 = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (3) @(negedge CLK);
        check_reset_outputs("rst");
        reset = 1'b0;
        load_bank(0);

        // Free-running dump with out_ready tied high.
        dump("basic", -1, 0, -1, nw, fv, lh, dc, nd, mx);
        check("basic_words", 32'(nw), 32'(NW));
        check("basic_first_valid_cyc", 32'(fv), 32'd3);
        check("basic_last_hs_cyc", 32'(lh), 32'(24 + CS_XTRA));
        check("basic_done_cyc", 32'(dc), 32'(lh + 1));
        check("basic_done_count", 32'(nd), 32'd1);
        check("basic_max_index", 32'(mx), 32'(NW - 1));
        @(negedge CLK);

        // Sink stalls for 5 cycles on word 3.
        dump("stall", 3, 5, -1, nw, fv, lh, dc, nd, mx);
        check("stall_words", 32'(nw), 32'(NW));
        check("stall_done_count", 32'(nd), 32'd1);
        @(negedge CLK);

        // Second start arrives mid-dump and must be dropped.
        dump("restart", -1, 0, 2, nw, fv, lh, dc, nd, mx);
        check("restart_words", 32'(nw), 32'(NW));
        check("restart_done_count", 32'(nd), 32'd1);
        repeat (3) @(negedge CLK);
        check("restart_not_queued_busy", 32'(busy), 32'd0);

        // Reset while word 5 is being offered.
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        found = 0;
        cyc = 0;
        while (cyc < 100 && !found) begin
            if (out_valid && out_index == 4'd5) found = 1;
            else begin
                @(negedge CLK);
                cyc++;
            end
        end
        check("midreset_reached_word5", 32'(found), 32'd1);
        reset = 1'b1;
        @(negedge CLK);
        check_reset_outputs("midreset");
        reset = 1'b0;
        dump("after_reset", -1, 0, -1, nw, fv, lh, dc, nd, mx);
        check("after_reset_words", 32'(nw), 32'(NW));
        check("after_reset_first_valid_cyc", 32'(fv), 32'd3);
        @(negedge CLK);

`ifdef REG_DUMP_CHECKSUM_EN
        // Sum wraps: 0xFFFF + 0x0002 = 0x0001.
        load_bank(1);
        dump("csum", -1, 0, -1, nw, fv, lh, dc, nd, mx);
        check("csum_words", 32'(nw), 32'd9);
        check("csum_value", 32'(word_exp(NR)), 32'h0001);
        check("csum_done_count", 32'(nd), 32'd1);
        @(negedge CLK);
`endif

        // Two-register instance: done on cycle 7, busy low on cycle 8.
        begin
            int hs2 = 0;
            int done2_cyc = -1;
            int idle2_cyc = -1;
            start2 = 1'b1;
            @(negedge CLK);
            start2 = 1'b0;
            for (int c = 1; c < 40 && idle2_cyc < 0; c++) begin
                if (out_valid2) begin
                    if (hs2 < 2) check("small_word_data", 32'(out_data2), 32'(exp_mem[hs2]));
                    check("small_word_index", 32'(out_index2), 32'(hs2));
                    hs2++;
                end
                if (done2) done2_cyc = c;
                if (done2_cyc >= 0 && !busy2 && !done2) idle2_cyc = c;
                @(negedge CLK);
            end
            check("small_words", 32'(hs2), 32'(NW2));
            check("small_done_cyc", 32'(done2_cyc), 32'(7 + CS_XTRA));
            check("small_busy_low_cyc", 32'(idle2_cyc), 32'(8 + CS_XTRA));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
Read-side sequencer for the CPU register bank. On a start pulse it reads registers R0..R(NUM_REGS-1) through the bank's synchronous read port. It then streams each 16-bit value out over a valid/ready handshake to a debug sink (UART framer or 7-segment scanner). It is the consumer/reader counterpart of the enable-written 16-bit registers.

Parameters:
NUM_REGS, 8, number of registers dumped (2..256)
DATA_W, 16, register and output word width
ADDR_W, 3, read-address width; must satisfy 2**ADDR_W >= NUM_REGS

Ports:
CLK  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high; forces IDLE
start  in  1  one-cycle request to begin a dump; honoured only in IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last word is accepted
rd_addr  out  ADDR_W  read address to register bank (registered)
rd_data  in  DATA_W  bank read data, valid exactly one cycle after rd_addr
out_data  out  DATA_W  word being offered to sink
out_index  out  ADDR_W+1  index of offered word (0..NUM_REGS-1; NUM_REGS = checksum word)
out_valid  out  1  word offered
out_ready  in  1  sink accepts when out_valid && out_ready

Behaviour:
- Reset values: busy=0, done=0, rd_addr=0, out_data=0, out_index=0, out_valid=0; FSM in IDLE; index counter at 0.
- Reset mid-operation abandons the dump immediately. There is no done pulse, and the next start begins again at R0.
- FSM states: IDLE, READ, CAPT, SEND, DONE.
- IDLE: on start, set idx=0 and rd_addr=0, go to READ. With start low, stay.
- READ: rd_addr holds idx; go to CAPT unconditionally. This is the bank's 1-cycle read latency.
- CAPT: out_data<=rd_data, out_index<=idx, out_valid<=1; go to SEND.
- SEND: out_valid and out_data are held stable while out_ready=0. There is no timeout.
- SEND, on handshake, out_valid<=0:
  - if idx==NUM_REGS-1, go to DONE;
  - else idx<=idx+1, rd_addr<=idx+1, go to READ.
- DONE: done=1 for exactly one cycle, then IDLE. busy drops in the IDLE cycle.
- start while busy is ignored; it is not queued.
- Timing: minimum 3 cycles per word with out_ready tied high. For NUM_REGS=8, the first out_valid appears 3 cycles after the start cycle. done asserts 1 cycle after the final handshake.
- out_valid never rises and falls in the same cycle. Between words it is low for at least 2 cycles.
- rd_data is sampled only in CAPT; values in other cycles are don't-care.

Optional Feature:
- Macro: REG_DUMP_CHECKSUM_EN.
- Defined:
  - A DATA_W-bit accumulator clears on start and adds each captured word modulo 2**DATA_W.
  - After the last register's handshake, the FSM enters state CSUM instead of DONE.
  - CSUM presents out_data=sum, out_index=NUM_REGS, out_valid=1, with the same hold rules as SEND.
  - On the CSUM handshake, go to DONE.
- Undefined: no accumulator, no CSUM state, and out_index never equals NUM_REGS.

Decomposition:
- Shared package cpu_dbg_pkg holds:
  - the state enum constants (IDLE, READ, CAPT, SEND, CSUM, DONE) as localparams;
  - DEFAULT_DATA_W=16;
  - DEFAULT_NUM_REGS=8.
- No sub-module is needed; FSM, counter and output register live in one module.
- Verification uses a behavioural 8x16 register-bank model with 1-cycle read latency, written through the normal enable-register path.

Test Plan:
- Bank R0..R7 = 0x1111,0x2222,...,0x8888; out_ready=1; pulse start → eight words in order 0x1111..0x8888, out_index 0..7, first out_valid 3 cycles after start, done 1 cycle after the last handshake.
- Same bank, out_ready low for 5 cycles on word 3 → out_data=0x4444 and out_index=3 held stable the whole stall, no word dropped or duplicated.
- start pulsed again during the dump (after word 2) → ignored, exactly 8 words total, single done pulse.
- reset asserted while in SEND on word 5 → next cycle all outputs at reset values; a fresh start emits R0 first.
- REG_DUMP_CHECKSUM_EN defined, R0..R7 = 0xFFFF,0x0002,0,0,0,0,0,0 → ninth word 0x0001 with out_index=8, then done.
- NUM_REGS=2, ADDR_W=1, out_ready=1 → exactly two words, done asserted on cycle 7 after start, busy low on cycle 8.
